// File: rtl/rice_bus_if.sv
// Data bus between the load/store unit (master) and a memory slave.
// Requests carry a byte strobe; zero strobe means read, and reads answer in order.
interface rice_bus_if #(
  parameter int unsigned XLEN = 32
);
  logic              request_valid;
  logic              request_ready;
  logic [XLEN-1:0]   address;
  logic [XLEN/8-1:0] strobe;
  logic [XLEN-1:0]   write_data;
  logic              response_valid;
  logic              response_ready;
  logic [XLEN-1:0]   read_data;

  modport master (
    output request_valid, address, strobe, write_data, response_ready,
    input  request_ready, response_valid, read_data
  );

  modport slave (
    input  request_valid, address, strobe, write_data, response_ready,
    output request_ready, response_valid, read_data
  );
endinterface

// File: rtl/rice_bus_sram.sv
// Word-organised data memory on the data bus: byte-strobed writes without a response,
// full-word reads returned through a small in-order response FIFO.
module rice_bus_sram #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned WORD_DEPTH     = 1024,
  parameter int unsigned RESPONSE_DEPTH = 2,
  parameter string       INIT_FILE      = ""
) (
  input logic       i_clk,
  input logic       i_rst_n,
  rice_bus_if.slave data_bus_if
);

  localparam int unsigned AW = $clog2(WORD_DEPTH);
  localparam int unsigned PW = $clog2(RESPONSE_DEPTH);
  localparam int unsigned CW = $clog2(RESPONSE_DEPTH + 1);
  localparam int unsigned NB = XLEN / 8;

  logic [XLEN-1:0] mem_q  [WORD_DEPTH];
  logic [XLEN-1:0] fifo_q [RESPONSE_DEPTH];

  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic [AW-1:0] word_idx;
  logic          req_ack;
  logic          is_write;
  logic          push;
  logic          pop;
  logic          unused_addr;

  assign word_idx = data_bus_if.address[2 +: AW];
  // Byte offset and bits above the index are ignored, so addresses wrap.
  assign unused_addr = ^{data_bus_if.address[1:0], data_bus_if.address[XLEN-1:AW+2]};

  // Ready depends only on reset and occupancy, never on same-cycle handshakes.
  assign data_bus_if.request_ready  = i_rst_n && (cnt_q != CW'(RESPONSE_DEPTH));
  assign data_bus_if.response_valid = (cnt_q != '0);
  assign data_bus_if.read_data      = fifo_q[rd_ptr_q];

  assign req_ack  = data_bus_if.request_valid && data_bus_if.request_ready;
  assign is_write = (data_bus_if.strobe != '0);
  assign push     = req_ack && !is_write;
  assign pop      = data_bus_if.response_valid && data_bus_if.response_ready;

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Memory is not reset; a read captures the word as it was before this edge.
  always_ff @(posedge i_clk) begin
    if (req_ack && is_write) begin
      for (int k = 0; k < NB; k++) begin
        if (data_bus_if.strobe[k]) mem_q[word_idx][8*k +: 8] <= data_bus_if.write_data[8*k +: 8];
      end
    end
    if (push) fifo_q[wr_ptr_q] <= mem_q[word_idx];
  end

endmodule
